// File: rtl/password_pkg.sv
// password_pkg: shared FSM state encoding and digit width default for the password setter
package password_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER   = 3'd1,
        S_CONFIRM = 3'd2,
        S_COMMIT  = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_e;
    localparam int DIGIT_W_DEF = 4;
endpackage

// File: rtl/pw_digit_buffer.sv
// pw_digit_buffer: shadow register array for entered digits, one write and one read port sharing idx
module pw_digit_buffer #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int ADDR_W  = 2
) (
    input  logic               CLK,
    input  logic               we,
    input  logic [ADDR_W-1:0]  idx,
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);
    logic [DIGIT_W-1:0] mem_q [DIGITS];
    // capture a digit at the current position; contents need no reset
    always_ff @(posedge CLK) begin
        if (we) mem_q[idx] <= din;
    end
    assign dout = mem_q[idx];
endmodule

// File: rtl/password_setter_gen.sv
// password_setter_gen: enter (and optionally confirm) a DIGITS-long code, then burst it into storage
module password_setter_gen import password_pkg::*; #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = DIGIT_W_DEF,
    parameter int CONFIRM = 1,
    localparam int ADDR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               cancel,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DIGIT_W-1:0] wr_data,
    input  logic               wr_ready,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    output logic [ADDR_W-1:0]  index,
    output logic [2:0]         state_dbg
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                mm_q, mm_d;
    logic                buf_we;
    logic [DIGIT_W-1:0]  buf_dout;
    logic                last;
    logic                diff;

    pw_digit_buffer #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .ADDR_W(ADDR_W)) u_buf (
        .CLK  (CLK),
        .we   (buf_we),
        .idx  (idx_q),
        .din  (digit),
        .dout (buf_dout)
    );

    assign last = idx_q == ADDR_W'(DIGITS - 1);
    assign diff = digit != buf_dout;

    // state, position and sticky mismatch registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mm_q    <= mm_d;
        end
    end

    // next-state logic; cancel wins over a digit in the same cycle, commit ignores control inputs
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mm_d    = mm_q;
        buf_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ENTER;
                    idx_d   = '0;
                    mm_d    = 1'b0;
                end
            end
            S_ENTER: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (digit_valid) begin
                    buf_we  = 1'b1;
                    idx_d   = last ? '0 : idx_q + 1'b1;
                    state_d = !last ? S_ENTER : (CONFIRM != 0) ? S_CONFIRM : S_COMMIT;
                end
            end
            S_CONFIRM: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (digit_valid) begin
                    mm_d    = mm_q | diff;
                    idx_d   = last ? '0 : idx_q + 1'b1;
                    state_d = !last ? S_CONFIRM : (mm_q | diff) ? S_ERR : S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (wr_ready) begin
                    idx_d   = last ? '0 : idx_q + 1'b1;
                    state_d = last ? S_DONE : S_COMMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                mm_d    = 1'b0;
            end
        endcase
    end

    assign wr_en     = state_q == S_COMMIT;
    assign wr_addr   = wr_en ? idx_q : '0;
    assign wr_data   = wr_en ? buf_dout : '0;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign mismatch  = state_q == S_ERR;
    assign index     = idx_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_password_setter_gen.sv
// tb_password_setter_gen: directed vector table plus hand sequences for the password setter
module tb_password_setter_gen;
    logic       CLK, RST;
    logic       start, cancel, digit_valid, wr_ready;
    logic [3:0] digit;
    logic       wr_en, busy, done, mismatch;
    logic [1:0] wr_addr, index;
    logic [3:0] wr_data;
    logic [2:0] state_dbg;

    logic       b_start, b_cancel, b_digit_valid, b_wr_ready;
    logic [7:0] b_digit;
    logic       b_wr_en, b_busy, b_done, b_mismatch;
    logic [2:0] b_wr_addr, b_index;
    logic [7:0] b_wr_data;
    logic [2:0] b_state_dbg;

    int checks = 0;
    int failures = 0;
    int wen_cnt = 0;
    int acc_cnt = 0;

    password_setter_gen dut_a (
        .CLK(CLK), .RST(RST), .start(start), .cancel(cancel), .digit_valid(digit_valid),
        .digit(digit), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done), .mismatch(mismatch), .index(index), .state_dbg(state_dbg)
    );

    password_setter_gen #(.DIGITS(6), .DIGIT_W(8), .CONFIRM(0)) dut_b (
        .CLK(CLK), .RST(RST), .start(b_start), .cancel(b_cancel), .digit_valid(b_digit_valid),
        .digit(b_digit), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .busy(b_busy), .done(b_done), .mismatch(b_mismatch), .index(b_index), .state_dbg(b_state_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (wr_en) wen_cnt++;
        if (wr_en && wr_ready) acc_cnt++;
    end

    typedef struct {
        logic s, c, v;
        logic [3:0] d;
        logic en;
        logic [1:0] a;
        logic [3:0] wd;
        logic bz, dn, mm;
        logic [1:0] ix;
        logic [2:0] st;
    } vec_t;

    vec_t tv[24];

    function automatic vec_t mk(logic s, logic c, logic v, logic [3:0] d, logic en, logic [1:0] a,
                                logic [3:0] wd, logic bz, logic dn, logic mm, logic [1:0] ix, logic [2:0] st);
        vec_t r;
        r.s = s; r.c = c; r.v = v; r.d = d; r.en = en; r.a = a; r.wd = wd;
        r.bz = bz; r.dn = dn; r.mm = mm; r.ix = ix; r.st = st;
        return r;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit = d;
        cyc();
        digit_valid = 1'b0;
    endtask

    logic [3:0] exp_d [4];
    int b, w0, a0;
    logic pat [7];

    initial begin
        RST = 1'b0;
        {start, cancel, digit_valid, digit, wr_ready} = '0;
        {b_start, b_cancel, b_digit_valid, b_digit} = '0;
        b_wr_ready = 1'b1;

        tv[0]  = mk(1,0,0,4'd0, 0,0,4'd0, 1,0,0, 0,3'd1);
        tv[1]  = mk(0,0,1,4'd3, 0,0,4'd0, 1,0,0, 1,3'd1);
        tv[2]  = mk(0,0,1,4'd1, 0,0,4'd0, 1,0,0, 2,3'd1);
        tv[3]  = mk(0,0,1,4'd4, 0,0,4'd0, 1,0,0, 3,3'd1);
        tv[4]  = mk(0,0,1,4'd1, 0,0,4'd0, 1,0,0, 0,3'd2);
        tv[5]  = mk(0,0,1,4'd3, 0,0,4'd0, 1,0,0, 1,3'd2);
        tv[6]  = mk(0,0,1,4'd1, 0,0,4'd0, 1,0,0, 2,3'd2);
        tv[7]  = mk(0,0,1,4'd4, 0,0,4'd0, 1,0,0, 3,3'd2);
        tv[8]  = mk(0,0,1,4'd1, 1,0,4'd3, 1,0,0, 0,3'd3);
        tv[9]  = mk(0,0,0,4'd0, 1,1,4'd1, 1,0,0, 1,3'd3);
        tv[10] = mk(0,0,0,4'd0, 1,2,4'd4, 1,0,0, 2,3'd3);
        tv[11] = mk(0,0,0,4'd0, 1,3,4'd1, 1,0,0, 3,3'd3);
        tv[12] = mk(0,0,0,4'd0, 0,0,4'd0, 1,1,0, 0,3'd4);
        tv[13] = mk(0,0,0,4'd0, 0,0,4'd0, 0,0,0, 0,3'd0);
        tv[14] = mk(1,0,0,4'd0, 0,0,4'd0, 1,0,0, 0,3'd1);
        tv[15] = mk(0,0,1,4'd3, 0,0,4'd0, 1,0,0, 1,3'd1);
        tv[16] = mk(0,0,1,4'd1, 0,0,4'd0, 1,0,0, 2,3'd1);
        tv[17] = mk(0,0,1,4'd4, 0,0,4'd0, 1,0,0, 3,3'd1);
        tv[18] = mk(0,0,1,4'd1, 0,0,4'd0, 1,0,0, 0,3'd2);
        tv[19] = mk(0,0,1,4'd3, 0,0,4'd0, 1,0,0, 1,3'd2);
        tv[20] = mk(0,0,1,4'd1, 0,0,4'd0, 1,0,0, 2,3'd2);
        tv[21] = mk(0,0,1,4'd4, 0,0,4'd0, 1,0,0, 3,3'd2);
        tv[22] = mk(0,0,1,4'd2, 0,0,4'd0, 1,0,1, 0,3'd5);
        tv[23] = mk(0,0,0,4'd0, 0,0,4'd0, 0,0,0, 0,3'd0);

        #12;
        chk("rst_a_outputs", {wr_en, wr_addr, wr_data, busy, done, mismatch, index, state_dbg}, 0);
        chk("rst_b_outputs", {b_wr_en, b_wr_addr, b_wr_data, b_busy, b_done, b_mismatch, b_index, b_state_dbg}, 0);
        @(negedge CLK);
        RST = 1'b1;
        cyc();

        wr_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            start = tv[i].s; cancel = tv[i].c; digit_valid = tv[i].v; digit = tv[i].d;
            cyc();
            chk($sformatf("v%0d_wr_en", i), wr_en, tv[i].en);
            chk($sformatf("v%0d_wr_addr", i), wr_addr, tv[i].a);
            chk($sformatf("v%0d_wr_data", i), wr_data, tv[i].wd);
            chk($sformatf("v%0d_busy", i), busy, tv[i].bz);
            chk($sformatf("v%0d_done", i), done, tv[i].dn);
            chk($sformatf("v%0d_mismatch", i), mismatch, tv[i].mm);
            chk($sformatf("v%0d_index", i), index, tv[i].ix);
            chk($sformatf("v%0d_state", i), state_dbg, tv[i].st);
        end
        {start, cancel, digit_valid, digit} = '0;

        w0 = wen_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        key(4'd3); key(4'd1); key(4'd4); key(4'd1);
        key(4'd3);
        cancel = 1'b1; digit_valid = 1'b1; digit = 4'd1;
        cyc();
        {cancel, digit_valid} = '0;
        chk("cancel_busy", busy, 0);
        chk("cancel_state", state_dbg, 0);
        chk("cancel_index", index, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("cancel_no_pulse", {done, mismatch, wr_en}, 0);
        end
        chk("cancel_no_writes", wen_cnt - w0, 0);

        exp_d[0] = 4'd5; exp_d[1] = 4'd6; exp_d[2] = 4'd7; exp_d[3] = 4'd8;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
        a0 = acc_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 2; k++) for (int j = 0; j < 4; j++) key(exp_d[j]);
        b = 0;
        for (int i = 0; i < 7; i++) begin
            wr_ready = pat[i];
            cancel = (i == 1);
            start = (i == 2);
            chk($sformatf("rdy%0d_wr_en", i), wr_en, 1);
            chk($sformatf("rdy%0d_wr_addr", i), wr_addr, b);
            chk($sformatf("rdy%0d_wr_data", i), wr_data, exp_d[b]);
            cyc();
            if (pat[i]) b++;
        end
        {cancel, start} = '0;
        wr_ready = 1'b1;
        chk("rdy_done", done, 1);
        chk("rdy_state", state_dbg, 4);
        chk("rdy_writes", acc_cnt - a0, 4);
        cyc();
        chk("rdy_idle", busy, 0);

        b_start = 1'b1; cyc(); b_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b_digit_valid = 1'b1;
            b_digit = 8'hA0 + 8'(i);
            cyc();
        end
        b_digit_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b%0d_wr_en", i), b_wr_en, 1);
            chk($sformatf("b%0d_wr_addr", i), b_wr_addr, i);
            chk($sformatf("b%0d_wr_data", i), b_wr_data, 8'hA0 + i);
            cyc();
        end
        chk("b_done", b_done, 1);
        chk("b_mismatch", b_mismatch, 0);
        cyc();
        chk("b_idle", b_busy, 0);

        start = 1'b1; cyc(); start = 1'b0;
        key(4'd9); key(4'd2);
        chk("pre_rst_index", index, 2);
        #3;
        RST = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_state", state_dbg, 0);
        chk("arst_index", index, 0);
        chk("arst_outputs", {wr_en, wr_addr, wr_data, done, mismatch}, 0);
        @(negedge CLK);
        RST = 1'b1;
        cyc();
        key(4'd5);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_index", index, 0);
        chk("post_rst_state", state_dbg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
